// File: rtl/ram_stream_reader.sv
// Burst reader: streams len words from a registered-output RAM starting at base.
// Optional out_last sideband is enabled by defining RAM_STREAM_READER_LAST_EN.
module ram_stream_reader #(
  parameter int D = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [D-1:0] base,
  input  logic [D:0]   len,
  output logic         busy,
  output logic         done,
  output logic         ram_re,
  output logic [D-1:0] ram_addr,
  input  logic [W-1:0] ram_rdata,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
`ifdef RAM_STREAM_READER_LAST_EN
  ,
  output logic         out_last
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t state_q, state_d;
  logic [D-1:0] addr_q, addr_d;
  logic [D:0] cnt_q, cnt_d;
  logic infl_q, infl_d;
  logic [1:0][W-1:0] data_q, data_d;
  logic wptr_q, wptr_d;
  logic rptr_q, rptr_d;
  logic [1:0] occ_q, occ_d;
  logic pop;
  logic [1:0] pend;
`ifdef RAM_STREAM_READER_LAST_EN
  logic [1:0] lastf_q, lastf_d;
  logic infl_last_q, infl_last_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    infl_d = 1'b0;
    data_d = data_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ram_re = 1'b0;
    done = 1'b0;
`ifdef RAM_STREAM_READER_LAST_EN
    lastf_d = lastf_q;
    infl_last_d = 1'b0;
`endif
    pop = (occ_q != 2'd0) && out_ready;
    // words already owed to the FIFO, counting a pop happening now
    pend = occ_q + {1'b0, infl_q} - {1'b0, pop};
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = base;
          cnt_d = len;
          state_d = (len == '0) ? DRAIN : READ;
        end
      end
      READ: begin
        if (pend < 2'd2) begin
          ram_re = 1'b1;
          infl_d = 1'b1;
          addr_d = addr_q + 1'b1;
          cnt_d = cnt_q - 1'b1;
`ifdef RAM_STREAM_READER_LAST_EN
          infl_last_d = (cnt_q == (D+1)'(1));
`endif
          if (cnt_q == (D+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!infl_q && occ_q == 2'd0) begin
          state_d = IDLE;
          done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (infl_q) begin
      data_d[wptr_q] = ram_rdata;
`ifdef RAM_STREAM_READER_LAST_EN
      lastf_d[wptr_q] = infl_last_q;
`endif
      wptr_d = ~wptr_q;
    end
    if (pop) rptr_d = ~rptr_q;
    occ_d = occ_q + {1'b0, infl_q} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      cnt_q <= '0;
      infl_q <= 1'b0;
      data_q <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      occ_q <= 2'd0;
`ifdef RAM_STREAM_READER_LAST_EN
      lastf_q <= 2'b00;
      infl_last_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      infl_q <= infl_d;
      data_q <= data_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q <= occ_d;
`ifdef RAM_STREAM_READER_LAST_EN
      lastf_q <= lastf_d;
      infl_last_q <= infl_last_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign ram_addr = addr_q;
  assign out_valid = (occ_q != 2'd0);
  assign out_data = data_q[rptr_q];
`ifdef RAM_STREAM_READER_LAST_EN
  assign out_last = out_valid & lastf_q[rptr_q];
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader with a registered RAM model.
// Expected words/addresses are queued at start; a negedge monitor checks them.
module tb_ram_stream_reader;
  localparam int D = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst, start;
  logic [D-1:0] base;
  logic [D:0] len;
  logic busy, done, ram_re;
  logic [D-1:0] ram_addr;
  logic [W-1:0] ram_rdata;
  logic out_valid;
  logic [W-1:0] out_data;
  logic out_ready;
`ifdef RAM_STREAM_READER_LAST_EN
  logic out_last;
`endif

  always #5 clk = ~clk;

  ram_stream_reader #(.D(D), .W(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base(base),
    .len(len),
    .busy(busy),
    .done(done),
    .ram_re(ram_re),
    .ram_addr(ram_addr),
    .ram_rdata(ram_rdata),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready)
`ifdef RAM_STREAM_READER_LAST_EN
    ,
    .out_last(out_last)
`endif
  );

  logic [W-1:0] mem [16];
  always @(posedge clk) if (ram_re) ram_rdata <= mem[ram_addr];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int first_re = -1;
  int first_v = -1;
  int st_cyc = 0;
  int outst = 0;
  int mode = 0;
  int rcnt = 0;
  logic [W-1:0] exp_d[$];
  bit exp_l[$];
  logic [D-1:0] exp_a[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_d.delete();
      exp_l.delete();
      exp_a.delete();
      outst = 0;
    end else begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      chk("outstanding_le_2", 32'(outst <= 2), 1);
      if (ram_re) begin
        if (first_re < 0) first_re = cyc;
        if (exp_a.size() == 0) chk("unexpected_read", 0, 1);
        else chk("ram_addr", 32'(ram_addr), 32'(exp_a.pop_front()));
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (out_valid && out_ready) begin
        if (exp_d.size() == 0) chk("unexpected_word", 0, 1);
        else begin
          chk("out_data", 32'(out_data), 32'(exp_d.pop_front()));
`ifdef RAM_STREAM_READER_LAST_EN
          chk("out_last", 32'(out_last), 32'(exp_l.pop_front()));
`else
          void'(exp_l.pop_front());
`endif
        end
      end
      outst = outst + int'(ram_re) - int'(out_valid && out_ready);
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rcnt++;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (rcnt % 3 == 0);
        default: out_ready = ((rcnt * 7) % 5) < 3;
      endcase
    end
  end

  task automatic start_burst(input int b, input int l, input bit expect_it);
    @(posedge clk);
    #1;
    start = 1'b1;
    base = D'(b);
    len = (D+1)'(l);
    if (expect_it) begin
      for (int i = 0; i < l; i++) begin
        exp_a.push_back(D'((b + i) % 16));
        exp_d.push_back(mem[(b + i) % 16]);
        exp_l.push_back(i == l - 1);
      end
      first_re = -1;
      first_v = -1;
      done_cyc = -1;
      st_cyc = cyc;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string nm);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_done_once"}, 32'(done_cnt), 32'(d0 + 1));
    chk({nm, "_busy_low"}, 32'(busy), 0);
    chk({nm, "_all_words"}, 32'(exp_d.size()), 0);
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 16; i++) mem[i] = W'(i * 29 + 7);
    ram_rdata = '0;
    rst = 1'b1;
    start = 1'b0;
    base = '0;
    len = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ram_re", 32'(ram_re), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    rst = 1'b0;

    d0 = done_cnt;
    start_burst(3, 4, 1);
    wait_done(d0, "b3l4");
    chk("lat_ram_re", 32'(first_re), 32'(st_cyc + 1));
    chk("lat_out_valid", 32'(first_v), 32'(st_cyc + 3));
    chk("lat_done", 32'(done_cyc), 32'(st_cyc + 7));

    d0 = done_cnt;
    start_burst(14, 4, 1);
    wait_done(d0, "wrap");

    d0 = done_cnt;
    start_burst(5, 0, 1);
    wait_done(d0, "len0");
    chk("len0_done_cyc", 32'(done_cyc), 32'(st_cyc + 1));
    chk("len0_no_read", 32'(first_re), 32'(-1));
    chk("len0_no_valid", 32'(first_v), 32'(-1));

    mode = 1;
    d0 = done_cnt;
    start_burst(0, 16, 1);
    wait_done(d0, "len16_slow");

    mode = 0;
    d0 = done_cnt;
    start_burst(5, 8, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_valid", 32'(out_valid), 0);
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_done", 32'(done_cnt), 32'(d0));
    d0 = done_cnt;
    start_burst(9, 2, 1);
    wait_done(d0, "after_rst");

    mode = 1;
    d0 = done_cnt;
    start_burst(2, 6, 1);
    @(posedge clk);
    #1;
    start = 1'b1;
    base = '0;
    len = 5'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(d0, "ignore_start");

    mode = 2;
    d0 = done_cnt;
    start_burst(11, 7, 1);
    wait_done(d0, "mixed_ready");

    repeat (5) @(posedge clk);
    #1;
    chk("final_addr_q", 32'(exp_a.size()), 0);
    chk("final_done_total", 32'(done_cnt), 7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 The block SHALL have parameter D, default 4, meaning RAM address width (RAM depth 2**D words).
REQ-002 The block SHALL have parameter W, default 8, meaning RAM data width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, a one-cycle request to begin a burst.
REQ-006 The block SHALL have port base, input, D, the first burst address, sampled with start.
REQ-007 The block SHALL have port len, input, D+1, the word count (0..2**D), sampled with start.
REQ-008 The block SHALL have port busy, output, 1, high while a burst is in progress.
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse at burst completion.
REQ-010 The block SHALL have port ram_re, output, 1, the RAM read enable.
REQ-011 The block SHALL have port ram_addr, output, D, the RAM read address.
REQ-012 The block SHALL have port ram_rdata, input, W, registered RAM read data, valid one cycle after the ram_re edge.
REQ-013 The block SHALL have port out_valid, output, 1, the stream valid.
REQ-014 The block SHALL have port out_data, output, W, the stream data.
REQ-015 The block SHALL have port out_ready, input, 1, the stream ready from downstream.

Function
REQ-016 FSM states SHALL be IDLE, READ and DRAIN; busy = (state != IDLE).
REQ-017 IDLE with start=1 SHALL latch base and len, then go to READ; if len=0, go to DRAIN instead.
REQ-018 start while busy SHALL be ignored, with no effect on the current burst.
REQ-019 In READ, ram_re SHALL be asserted combinationally only when issued-but-unconsumed words (in-flight + buffered) < 2.
REQ-020 Each ram_re SHALL advance the address by 1 modulo 2**D (wrap 2**D-1 -> 0) and decrement the remaining count.
REQ-021 When the remaining count reaches 0 after a read, the FSM SHALL go to DRAIN.
REQ-022 ram_rdata SHALL be captured into a 2-entry output FIFO on the edge after the cycle following ram_re; the credit rule guarantees no overflow.
REQ-023 out_valid SHALL equal FIFO non-empty; out_data SHALL be the FIFO head; a word SHALL pop on out_valid && out_ready.
REQ-024 Push and pop in the same cycle SHALL both take effect, with occupancy unchanged.
REQ-025 Minimum latency SHALL be: start in cycle 0, ram_re in cycle 1, out_valid in cycle 3.
REQ-026 With out_ready held high, the block SHALL sustain one word per cycle.
REQ-027 DRAIN SHALL go to IDLE with done=1 for one cycle once no read is in flight and the FIFO is empty; for len=0 this is the cycle after start.
REQ-028 Words SHALL be output in address order, exactly len words per burst, none dropped or duplicated under any out_ready pattern.
REQ-029 ram_addr SHALL be don't-care while ram_re=0.

Reset
REQ-030 rst SHALL take priority over all other inputs: state=IDLE, FIFO emptied, in-flight flag cleared, address and count cleared.
REQ-031 After reset, busy=0, done=0, ram_re=0, out_valid=0; out_data is don't-care.
REQ-032 rst mid-burst SHALL abandon the burst without a done pulse; a RAM response arriving after reset SHALL be discarded.

Configuration
REQ-033 The macro RAM_STREAM_READER_LAST_EN SHALL control an extra output out_last (1 bit).
REQ-034 With RAM_STREAM_READER_LAST_EN defined, out_last SHALL be high alongside out_valid for the final word of a burst; it resets to 0 and is stored per FIFO entry.
REQ-035 Without RAM_STREAM_READER_LAST_EN, the out_last port and its storage SHALL not exist; all other behaviour is identical.

Verification
REQ-036 base=3, len=4, out_ready=1 -> ram_addr 3,4,5,6 on consecutive cycles; out_data = mem[3..6] in cycles 3..6; done pulse once; busy low afterwards.
REQ-037 D=4, base=14, len=4 -> addresses 14,15,0,1 in order; 4 words out.
REQ-038 len=0 -> no ram_re; done=1 exactly one cycle after start; out_valid stays 0.
REQ-039 len=16, out_ready toggling 1,0,0,1,... -> in-flight+buffered never exceeds 2; all 16 words in order; none lost.
REQ-040 rst asserted 2 cycles into a len=8 burst -> next cycle busy=0, out_valid=0; no done; a later start with len=2 delivers exactly 2 correct words.
REQ-041 start pulsed again mid-burst (base=0, len=5) -> ignored; only the original burst's words appear; with LAST_EN defined, out_last=1 only on its final word.
